// File: rtl/popcount_unit.sv
// Multi-cycle population count: latches an operand on start and sums its set bits
// one CHUNK_WIDTH slice per cycle, presenting the zero-extended count with a done pulse.
//
// state | meaning
// IDLE  | waiting for start; result held on popcount_out
// RUN   | accumulating one chunk per edge, idx counts chunks consumed
module popcount_unit #(
  parameter int DATA_WIDTH  = 1024,
  parameter int CHUNK_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] operand_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] popcount_out
);

  localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]        acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   pop_q, pop_d;
  logic [CNT_W-1:0]        chunk_ones;
  logic [CNT_W-1:0]        acc_sum;

  // Single chunk-wide adder tree shared by every iteration.
  always_comb begin
    chunk_ones = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      chunk_ones = chunk_ones + CNT_W'(sr_q[i]);
    end
  end

  assign acc_sum = acc_q + chunk_ones;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pop_d   = pop_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = operand_in;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        sr_d  = sr_q >> CHUNK_WIDTH;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          pop_d   = DATA_WIDTH'(acc_sum);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pop_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pop_q   <= pop_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign popcount_out = pop_q;

endmodule

// File: tb/tb_popcount_unit.sv
// Directed self-checking bench for popcount_unit at the default 16-chunk geometry
// and at the single-chunk (N=1) geometry.
module tb_popcount_unit;
  localparam int DW = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, busy, done;
  logic [DW-1:0] operand, pop;
  logic          rst1, start1, busy1, done1;
  logic [DW-1:0] op1, pop1;

  int n_pass  = 0;
  int n_total = 0;

  popcount_unit #(.DATA_WIDTH(DW), .CHUNK_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .operand_in(operand),
    .busy(busy), .done(done), .popcount_out(pop)
  );

  popcount_unit #(.DATA_WIDTH(DW), .CHUNK_WIDTH(1024)) dut_n1 (
    .clk(clk), .rst(rst1), .start(start1), .operand_in(op1),
    .busy(busy1), .done(done1), .popcount_out(pop1)
  );

  // Stimulus only: launch one op on the 16-chunk instance and report what was seen.
  task automatic do_op(input logic [DW-1:0] v, output int lat, output int busy_cnt,
                       output logic [DW-1:0] res);
    start = 1'b1; operand = v;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = -1; res = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin lat = c; res = pop; break; end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; operand = '1;
    rst1 = 1'b1; start1 = 1'b1; op1 = '1;
    repeat (3) @(negedge clk);
    n_total++; if ({busy, done} !== 2'b00) $display("FAIL reset_ctl: busy/done=%b want 00", {busy, done}); else n_pass++;
    n_total++; if (pop !== '0) $display("FAIL reset_pop: got %0h want 0", pop); else n_pass++;
    n_total++; if ({busy1, done1, |pop1} !== 3'b000) $display("FAIL reset_n1: busy/done/pop=%b want 000", {busy1, done1, |pop1}); else n_pass++;
    rst = 1'b0; start = 1'b0; operand = '0;
    rst1 = 1'b0; start1 = 1'b0; op1 = '0;
    @(negedge clk);
  endtask

  task automatic test_zeros();
    int lat, bc; logic [DW-1:0] res;
    do_op('0, lat, bc, res);
    n_total++; if (lat !== 16) $display("FAIL zeros_latency: got %0d want 16", lat); else n_pass++;
    n_total++; if (bc !== 16) $display("FAIL zeros_busy_cycles: got %0d want 16", bc); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL zeros_busy_at_done: got %b want 0", busy); else n_pass++;
    n_total++; if (res !== '0) $display("FAIL zeros_result: got %0h want 0", res); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b0) $display("FAIL zeros_done_pulse: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_patterns();
    int lat, bc; logic [DW-1:0] res, v, exp_v;
    do_op('1, lat, bc, res);
    exp_v = DW'(1024);
    n_total++; if (res !== exp_v) $display("FAIL ones_result: got %0h want 400", res); else n_pass++;
    v = '0; v[1023] = 1'b1;
    do_op(v, lat, bc, res);
    n_total++; if (res !== DW'(1)) $display("FAIL msb_result: got %0h want 1", res); else n_pass++;
    v = '0; v[0] = 1'b1;
    do_op(v, lat, bc, res);
    n_total++; if (res !== DW'(1)) $display("FAIL lsb_result: got %0h want 1", res); else n_pass++;
    n_total++; if (lat !== 16) $display("FAIL lsb_latency: got %0d want 16", lat); else n_pass++;
    v = {128{8'hAA}};
    do_op(v, lat, bc, res);
    n_total++; if (res !== DW'(512)) $display("FAIL aa_result: got %0h want 200", res); else n_pass++;
    v = {{960{1'b0}}, {64{1'b1}}};
    do_op(v, lat, bc, res);
    n_total++; if (res !== DW'(64)) $display("FAIL low64_result: got %0h want 40", res); else n_pass++;
  endtask

  task automatic test_hold();
    int bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pop !== DW'(64) || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL hold_idle: %0d bad cycles, want 0", bad); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ndone = 0, bad_t = 0, bad_v = 0;
    start = 1'b1; operand = '1;
    @(negedge clk);
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (done) begin
        if (c != 16 + 17 * ndone) bad_t++;
        if (pop !== DW'(1024)) bad_v++;
        ndone++;
      end
      if (c == 56) begin operand = '0; start = 1'b0; end
    end
    n_total++; if (ndone !== 4) $display("FAIL b2b_count: got %0d want 4", ndone); else n_pass++;
    n_total++; if (bad_t !== 0) $display("FAIL b2b_spacing: %0d off-period dones, want 0", bad_t); else n_pass++;
    n_total++; if (bad_v !== 0) $display("FAIL b2b_value: %0d wrong results, want 0", bad_v); else n_pass++;
  endtask

  task automatic test_start_during_run();
    int ndone = 0, at = -1; logic [DW-1:0] res = '0;
    start = 1'b1; operand = '1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (done) begin ndone++; at = c; res = pop; end
      if (c == 2) begin start = 1'b1; operand = '0; end
      if (c == 3) start = 1'b0;
    end
    n_total++; if (ndone !== 1) $display("FAIL run_start_count: got %0d want 1", ndone); else n_pass++;
    n_total++; if (at !== 16) $display("FAIL run_start_time: got %0d want 16", at); else n_pass++;
    n_total++; if (res !== DW'(1024)) $display("FAIL run_start_value: got %0h want 400", res); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int ndone = 0, lat, bc; logic [DW-1:0] res;
    start = 1'b1; operand = '1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if ({busy, done} !== 2'b00) $display("FAIL abort_ctl: busy/done=%b want 00", {busy, done}); else n_pass++;
    n_total++; if (pop !== '0) $display("FAIL abort_pop: got %0h want 0", pop); else n_pass++;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_total++; if (ndone !== 0) $display("FAIL abort_no_done: got %0d want 0", ndone); else n_pass++;
    do_op({{960{1'b0}}, {64{1'b1}}}, lat, bc, res);
    n_total++; if (lat !== 16) $display("FAIL abort_recover_latency: got %0d want 16", lat); else n_pass++;
    n_total++; if (res !== DW'(64)) $display("FAIL abort_recover_value: got %0h want 40", res); else n_pass++;
  endtask

  task automatic test_single_chunk();
    start1 = 1'b1; op1 = {128{8'hAA}};
    @(negedge clk);
    start1 = 1'b0;
    n_total++; if ({busy1, done1} !== 2'b10) $display("FAIL n1_accept: busy/done=%b want 10", {busy1, done1}); else n_pass++;
    @(negedge clk);
    n_total++; if ({busy1, done1} !== 2'b01) $display("FAIL n1_done: busy/done=%b want 01", {busy1, done1}); else n_pass++;
    n_total++; if (pop1 !== DW'(512)) $display("FAIL n1_aa_value: got %0h want 200", pop1); else n_pass++;
    start1 = 1'b1; op1 = '1;
    @(negedge clk);
    start1 = 1'b0;
    n_total++; if (done1 !== 1'b0) $display("FAIL n1_done_clear: got %b want 0", done1); else n_pass++;
    @(negedge clk);
    n_total++; if (done1 !== 1'b1 || pop1 !== DW'(1024)) $display("FAIL n1_ones: done=%b pop=%0h want 1/400", done1, pop1); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_patterns();
    test_hold();
    test_back_to_back();
    test_start_during_run();
    test_reset_mid_run();
    test_single_chunk();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
